// File: rtl/arm_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : arm_multicycle_controller
// Description : Multicycle ARM control unit: state sequencer, ALU decoder,
//               NZCV flag register and condition-gated write enables.
// Revision    : 1.0 - initial release
// ============================================================================
module arm_multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] c_OP_DP  = 2'b00;
    localparam logic [1:0] c_OP_MEM = 2'b01;
    localparam logic [1:0] c_OP_BR  = 2'b10;

    state_t     r_state;
    logic [3:0] r_flags;
    logic       r_cond_ex;

    logic       w_cond_ex;
    logic       w_alu_op;
    logic       w_regw;
    logic       w_memw;
    logic       w_branch;
    logic       w_pcs;
    logic       w_rd_pc;
    logic [1:0] w_alu_ctrl;
    logic [1:0] w_flagw;
    logic       w_nowrite;

    logic w_n, w_z, w_c, w_v;
    assign {w_n, w_z, w_c, w_v} = r_flags;

    // Condition evaluated against the stored flags, captured at end of DECODE.
    always_comb begin
        w_cond_ex = 1'b0;
        case (Cond)
            4'b0000: w_cond_ex = w_z;
            4'b0001: w_cond_ex = ~w_z;
            4'b0010: w_cond_ex = w_c;
            4'b0011: w_cond_ex = ~w_c;
            4'b0100: w_cond_ex = w_n;
            4'b0101: w_cond_ex = ~w_n;
            4'b0110: w_cond_ex = w_v;
            4'b0111: w_cond_ex = ~w_v;
            4'b1000: w_cond_ex = w_c & ~w_z;
            4'b1001: w_cond_ex = ~w_c | w_z;
            4'b1010: w_cond_ex = (w_n == w_v);
            4'b1011: w_cond_ex = (w_n != w_v);
            4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
            4'b1101: w_cond_ex = w_z | (w_n != w_v);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    assign w_alu_op = (r_state == S_EXECR) || (r_state == S_EXECI);
    assign w_regw   = (r_state == S_MEMWB) || (r_state == S_ALUWB);
    assign w_memw   = (r_state == S_MEMWR);
    assign w_branch = (r_state == S_BRANCH);
    assign w_rd_pc  = (Rd == 4'hF);
    assign w_pcs    = (w_regw & w_rd_pc) | w_branch;

    // Unsupported commands fall through as no-write, no-flag operations.
    always_comb begin
        w_alu_ctrl = 2'b00;
        w_flagw    = 2'b00;
        w_nowrite  = 1'b0;
        if (w_alu_op) begin
            case (Funct[4:1])
                4'b0100: begin
                    w_alu_ctrl = 2'b00;
                    w_flagw    = {2{Funct[0]}};
                end
                4'b0010: begin
                    w_alu_ctrl = 2'b01;
                    w_flagw    = {2{Funct[0]}};
                end
                4'b0000: begin
                    w_alu_ctrl = 2'b10;
                    w_flagw    = {Funct[0], 1'b0};
                end
                4'b1100: begin
                    w_alu_ctrl = 2'b11;
                    w_flagw    = {Funct[0], 1'b0};
                end
                4'b1010: begin
                    w_alu_ctrl = 2'b01;
                    w_flagw    = 2'b11;
                    w_nowrite  = 1'b1;
                end
                default: begin
                    w_alu_ctrl = 2'b00;
                    w_flagw    = 2'b00;
                    w_nowrite  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_flags   <= 4'b0000;
            r_cond_ex <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    case (Op)
                        c_OP_MEM: r_state <= S_MEMADR;
                        c_OP_DP:  r_state <= Funct[5] ? S_EXECI : S_EXECR;
                        c_OP_BR:  r_state <= S_BRANCH;
                        default:  r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR: r_state <= Funct[0] ? S_MEMRD : S_MEMWR;
                S_MEMRD:  r_state <= S_MEMWB;
                S_MEMWB:  r_state <= S_FETCH;
                S_MEMWR:  r_state <= S_FETCH;
                S_EXECR,
                S_EXECI:  r_state <= w_nowrite ? S_FETCH : S_ALUWB;
                S_ALUWB:  r_state <= S_FETCH;
                S_BRANCH: r_state <= S_FETCH;
                default:  r_state <= S_FETCH;
            endcase

            if (r_state == S_DECODE) begin
                r_cond_ex <= w_cond_ex;
            end

            if (w_alu_op && r_cond_ex) begin
                if (w_flagw[1]) begin
                    r_flags[3:2] <= ALUFlags[3:2];
                end
                if (w_flagw[0]) begin
                    r_flags[1:0] <= ALUFlags[1:0];
                end
            end
        end
    end

    // Write enables are held low for the whole time reset is asserted.
    always_comb begin
        PCWrite    = rst_n & ((r_state == S_FETCH) | (w_pcs & r_cond_ex));
        RegWrite   = rst_n & w_regw & r_cond_ex & ~w_rd_pc;
        MemWrite   = rst_n & w_memw & r_cond_ex;
        IRWrite    = rst_n & (r_state == S_FETCH);
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = w_alu_ctrl;
        ImmSrc     = Op;
        RegSrc     = {Op == c_OP_MEM, Op == c_OP_BR};
        case (r_state)
            S_FETCH,
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: ALUSrcB   = 2'b01;
            S_MEMRD:  AdrSrc    = 1'b1;
            S_MEMWB:  ResultSrc = 2'b01;
            S_MEMWR:  AdrSrc    = 1'b1;
            S_EXECI:  ALUSrcB   = 2'b01;
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
            end
            default: begin
                AdrSrc    = 1'b0;
                ResultSrc = 2'b00;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/arm_multicycle_controller.md
# arm_multicycle_controller

Control unit for the multicycle ARM core. It sequences the shared datapath (one memory port, one ALU, one register file) through fetch, decode, execute and writeback states. It decodes data-processing commands into ALU control and flag-write enables, and owns the NZCV flag register. It also gates every architectural write on the instruction's condition field.

## Interface
Parameters: none.

- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- Cond  in  4  Instr[31:28], stable from the cycle after FETCH
- Op  in  2  Instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined
- Funct  in  6  Instr[25:20]: [5] immediate, [4:1] cmd, [0] S / L
- Rd  in  4  Instr[15:12]
- ALUFlags  in  4  {N,Z,C,V} from the ALU, same cycle
- PCWrite, MemWrite, RegWrite, IRWrite  out  1 each  datapath write enables
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- ALUSrcA  out  1  0 = register A, 1 = PC
- ALUSrcB  out  2  00 = register B, 01 = extended immediate, 10 = constant 4
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ImmSrc  out  2  equals Op
- RegSrc  out  2  [0] = (Op==10), [1] = (Op==01)
- ALUControl  out  2  00 add, 01 sub, 10 and, 11 orr

## Operation
States, with outputs not listed being 0:
- FETCH: AdrSrc 0, IRWrite 1, ALUSrcA 1, ALUSrcB 10, ResultSrc 10, PCWrite 1.
- DECODE: ALUSrcA 1, ALUSrcB 10, ResultSrc 10.
- MEMADR: ALUSrcB 01, ALU add.
- MEMRD: AdrSrc 1.
- MEMWB: ResultSrc 01, RegW.
- MEMWR: AdrSrc 1, MemW.
- EXECR: ALUSrcB 00, ALUOp.
- EXECI: ALUSrcB 01, ALUOp.
- ALUWB: ResultSrc 00, RegW.
- BRANCH: ALUSrcB 01, ResultSrc 10, ALU add, Branch.

Transitions:
- FETCH → DECODE.
- DECODE:
  - Op 01 → MEMADR.
  - Op 00 with Funct[5]=0 → EXECR; with Funct[5]=1 → EXECI.
  - Op 10 → BRANCH.
  - Op 11 → FETCH (treated as a no-op).
- MEMADR → MEMRD if Funct[0]=1, else MEMWR.
- MEMRD → MEMWB → FETCH.
- MEMWR → FETCH.
- EXECR and EXECI → FETCH if NoWrite, else ALUWB.
- ALUWB → FETCH.
- BRANCH → FETCH.

ALU decode, applied only while ALUOp=1; otherwise ALUControl=00, FlagW=00, NoWrite=0:
- cmd 0100 ADD: ALUControl 00; FlagW 11 if S.
- cmd 0010 SUB: ALUControl 01; FlagW 11 if S.
- cmd 0000 AND: ALUControl 10; FlagW 10 if S.
- cmd 1100 ORR: ALUControl 11; FlagW 10 if S.
- cmd 1010 CMP: ALUControl 01, NoWrite 1, FlagW 11.
- Any other cmd: ALUControl 00, FlagW 00, NoWrite 1, so it has no architectural effect.

Condition check:
- CondEx is evaluated on the stored flags:
  - EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V
  - HI C&~Z, LS ~C|Z, GE N==V, LT N!=V
  - GT ~Z&(N==V), LE Z|(N!=V)
  - 1110 true, 1111 false.
- cond_ex_q captures CondEx at the end of DECODE. Every gate below uses cond_ex_q, never live CondEx, so a flag update in EXECUTE cannot alter the writeback decision.

Write gating:
- PCS = (RegW & Rd==15) | Branch.
- PCWrite = (state==FETCH) | (PCS & cond_ex_q).
- RegWrite = RegW & cond_ex_q & ~(Rd==15).
- MemWrite = MemW & cond_ex_q.

Flag register:
- NZ updates from ALUFlags[3:2] on a rising edge in EXECR/EXECI when FlagW[1] & cond_ex_q.
- CV updates from ALUFlags[1:0] under the same condition with FlagW[0].

## Timing
- Reset, asynchronous on rst_n low:
  - state = FETCH, flags = 0000, cond_ex_q = 0.
  - While rst_n is low, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
  - Other outputs take their FETCH values.
- The first fetch occurs on the first rising edge after rst_n deasserts.
- A reset asserted mid-instruction aborts it immediately: no write enable is asserted in that cycle, and flags are cleared.
- Cycles per instruction:
  - LDR 5, STR 4.
  - Data-processing 4; CMP and unsupported commands 3.
  - B 3; Op 11 2.
- A failed condition traverses the same states with the same cycle count, but with no PC (beyond PC+4), register, memory or flag write.
- All outputs are Moore-decoded from state plus the registered cond_ex_q and flags. The only Mealy input is ALUFlags, which is sampled on the clock edge only.

## Test plan
- Reset: hold rst_n=0 for 3 cycles → all write enables 0, flags 0000; first cycle after release shows IRWrite=1, PCWrite=1, ALUSrcB=10.
- ADDS R1,R2,R3 (Op 00, Funct 001001, Cond 1110) with ALUFlags=0100 → EXECR then ALUWB, ALUControl=00, RegWrite=1 in cycle 4, flags become 0100.
- CMP (Funct 010101) then BEQ with ALUFlags=0100 → CMP takes 3 cycles with RegWrite never asserted; the branch takes PCWrite=1 in BRANCH.
- BNE after Z=1 → BRANCH state with PCWrite=0 and 3-cycle CPI.
- LDR (Op 01, Funct[0]=1) → AdrSrc=1 in MEMRD, ResultSrc=01 with RegWrite=1 in MEMWB, 5 cycles. STR → MemWrite=1 in cycle 4.
- ADDEQ R15 with Z=1 → PCWrite=1 and RegWrite=0 in ALUWB. Same instruction with Cond 1111 → no writes.
